apb_master_arbiter: RTL and testbench

Multi-requester APB master controller: arbitrates between `NO_OF_REQUESTERS` transaction sources with round-robin priority and runs each granted transfer on one shared APB bus. Decodes the address into a one-hot `psel` across `NO_OF_SLAVES` slave windows and sequences the IDLE/SETUP/ACCESS protocol, including wait states and a wait-state timeout. Sits between the master-side stimulus/bridge logic and the slave interfaces. Returns read data and error status to the originating requester.

---
 rtl/apb_master_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin multi-requester APB master with address decode and wait-state timeout
module apb_master_arbiter #(
    parameter int NO_OF_REQUESTERS  = 2,
    parameter int NO_OF_SLAVES      = 1,
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int SLAVE_MEMORY_SIZE = 12,
    parameter int SLAVE_MEMORY_GAP  = 5,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic                                         pclk,
    input  logic                                         preset,
    input  logic [NO_OF_REQUESTERS-1:0]                  req_valid,
    output logic [NO_OF_REQUESTERS-1:0]                  req_ready,
    input  logic [NO_OF_REQUESTERS-1:0]                  req_write,
    input  logic [NO_OF_REQUESTERS*ADDRESS_WIDTH-1:0]    req_addr,
    input  logic [NO_OF_REQUESTERS*DATA_WIDTH-1:0]       req_wdata,
    input  logic [NO_OF_REQUESTERS*(DATA_WIDTH/8)-1:0]   req_strb,
    input  logic [NO_OF_REQUESTERS*3-1:0]                req_prot,
    output logic [NO_OF_REQUESTERS-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]                        rsp_rdata,
    output logic                                         rsp_err,
    output logic [NO_OF_SLAVES-1:0]                      psel,
    output logic                                         penable,
    output logic                                         pwrite,
    output logic [ADDRESS_WIDTH-1:0]                     paddr,
    output logic [DATA_WIDTH-1:0]                        pwdata,
    output logic [DATA_WIDTH/8-1:0]                      pstrb,
    output logic [2:0]                                   pprot,
    input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0]           prdata,
    input  logic [NO_OF_SLAVES-1:0]                      pready,
    input  logic [NO_OF_SLAVES-1:0]                      pslverr,
    output logic [2:0]                                   fsm_state
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int REQ_W = (NO_OF_REQUESTERS > 1) ? $clog2(NO_OF_REQUESTERS) : 1;
    localparam int SLV_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [63:0] WINDOW = 64'(SLAVE_MEMORY_SIZE) * 64'd1024;
    localparam logic [63:0] STRIDE = WINDOW + 64'(SLAVE_MEMORY_GAP);

    typedef enum logic [2:0] {
        NO_STATE = 3'd0,
        IDLE     = 3'd1,
        SETUP    = 3'd2,
        ACCESS   = 3'd3
    } state_t;

    state_t state, next_state;

    logic [REQ_W-1:0]         last_grant;
    logic [REQ_W-1:0]         cap_req;
    logic [SLV_W-1:0]         cap_slv;
    logic                     cap_write;
    logic [ADDRESS_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0]    cap_wdata;
    logic [STRB_WIDTH-1:0]    cap_strb;
    logic [2:0]               cap_prot;
    logic [CNT_W-1:0]         wait_cnt;
    logic [NO_OF_REQUESTERS-1:0] rsp_valid_r;
    logic [DATA_WIDTH-1:0]    rsp_rdata_r;
    logic                     rsp_err_r;

    logic                     gnt_found;
    logic [REQ_W-1:0]         gnt_idx;
    logic [31:0]              cand;
    logic [ADDRESS_WIDTH-1:0] gnt_addr;
    logic                     grant;
    logic                     dec_hit;
    logic [SLV_W-1:0]         dec_idx;
    logic [63:0]              addr_ext;
    logic [63:0]              base;
    logic                     cur_ready;
    logic                     cur_err;
    logic [DATA_WIDTH-1:0]    cur_rdata;
    logic                     timeout;

    // Round-robin search: first valid requester after the last one granted.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NO_OF_REQUESTERS; i++) begin
            cand = (32'(last_grant) + 32'(i)) % 32'(NO_OF_REQUESTERS);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[REQ_W-1:0];
            end
        end
    end

    assign gnt_addr = req_addr[32'(gnt_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign grant    = (state == IDLE) && gnt_found && !preset;

    // Window decode of the granted address; gap bytes and addresses past the last slave miss.
    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = '0;
        base     = '0;
        addr_ext = 64'(gnt_addr);
        for (int k = 0; k < NO_OF_SLAVES; k++) begin
            base = STRIDE * 64'(k);
            if (!dec_hit && (addr_ext >= base) && (addr_ext < base + WINDOW)) begin
                dec_hit = 1'b1;
                dec_idx = SLV_W'(k);
            end
        end
    end

    assign cur_ready = pready[cap_slv];
    assign cur_err   = pslverr[cap_slv];
    assign cur_rdata = prdata[32'(cap_slv)*DATA_WIDTH +: DATA_WIDTH];
    // A ready slave on the last allowed cycle still completes normally.
    assign timeout   = (state == ACCESS) && !cur_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    // State register.
    always_ff @(posedge pclk) begin
        if (preset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; unmapped grants stay in IDLE and answer from there.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant && dec_hit) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (cur_ready || timeout) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus strobes, accept pulse and state report.
    always_comb begin
        psel      = '0;
        penable   = 1'b0;
        req_ready = '0;
        fsm_state = state;
        if (state == SETUP || state == ACCESS) psel[cap_slv] = 1'b1;
        if (state == ACCESS)                   penable = 1'b1;
        if (grant)                             req_ready[gnt_idx] = 1'b1;
    end

    // Request capture, wait counting and registered response; reset drops any pending response.
    always_ff @(posedge pclk) begin
        if (preset) begin
            last_grant  <= REQ_W'(NO_OF_REQUESTERS - 1);
            cap_req     <= '0;
            cap_slv     <= '0;
            cap_write   <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            cap_strb    <= '0;
            cap_prot    <= '0;
            wait_cnt    <= '0;
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= '0;
            if (grant) begin
                last_grant <= gnt_idx;
                cap_req    <= gnt_idx;
                cap_slv    <= dec_idx;
                cap_write  <= req_write[gnt_idx];
                cap_addr   <= gnt_addr;
                cap_wdata  <= req_wdata[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                cap_strb   <= req_strb[32'(gnt_idx)*STRB_WIDTH +: STRB_WIDTH];
                cap_prot   <= req_prot[32'(gnt_idx)*3 +: 3];
                wait_cnt   <= '0;
                if (!dec_hit) begin
                    rsp_valid_r[gnt_idx] <= 1'b1;
                    rsp_rdata_r          <= '0;
                    rsp_err_r            <= 1'b1;
                end
            end
            if (state == ACCESS) begin
                if (cur_ready) begin
                    rsp_valid_r[cap_req] <= 1'b1;
                    rsp_rdata_r          <= cap_write ? '0 : cur_rdata;
                    rsp_err_r            <= cur_err;
                end else if (timeout) begin
                    rsp_valid_r[cap_req] <= 1'b1;
                    rsp_rdata_r          <= '0;
                    rsp_err_r            <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign pwrite    = cap_write;
    assign paddr     = cap_addr;
    assign pwdata    = cap_wdata;
    assign pstrb     = cap_strb;
    assign pprot     = cap_prot;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - randomized self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;
    localparam int NR  = 2;
    localparam int NS  = 2;
    localparam int TO  = 16;
    localparam int WIN = 12 * 1024;
    localparam int S   = WIN + 5;

    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_strb;
    logic [5:0]  req_prot;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [63:0] prdata;
    logic [1:0]  pready, pslverr;
    logic [2:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    int last_g   = NR - 1;
    int slv_wait = 0;
    int acc      = 0;
    logic [31:0] slv_rdata [NS];
    logic [NS-1:0] slv_err;

    apb_master_arbiter #(
        .NO_OF_REQUESTERS(NR), .NO_OF_SLAVES(NS), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
        .SLAVE_MEMORY_SIZE(12), .SLAVE_MEMORY_GAP(5), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .fsm_state(fsm_state)
    );

    always #5 pclk = ~pclk;

    // Slave model: ready after slv_wait wait states in ACCESS.
    always @(negedge pclk) acc = penable ? acc + 1 : 0;
    assign pready[0] = psel[0] && penable && (acc == slv_wait + 1);
    assign pready[1] = psel[1] && penable && (acc == slv_wait + 1);
    assign prdata    = {slv_rdata[1], slv_rdata[0]};
    assign pslverr   = slv_err;

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_req(input int r, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [2:0] prot);
        req_write[r]         = wr;
        req_addr[r*32 +: 32] = addr;
        req_wdata[r*32 +: 32] = wdata;
        req_strb[r*4 +: 4]   = strb;
        req_prot[r*3 +: 3]   = prot;
    endtask

    function automatic int rr_pick(input int last, input logic [1:0] v);
        int pick;
        pick = -1;
        for (int i = 1; i <= NR; i++)
            if (pick < 0 && v[(last + i) % NR]) pick = (last + i) % NR;
        return pick;
    endfunction

    // One isolated transfer from requester r, predicted from the address map and slave behaviour.
    task automatic run_single(input int r, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [2:0] prot, input int w, input string tag);
        bit mapped;
        int k, exp_lat, exp_pen, c, pen_cnt;
        logic exp_err;
        logic [31:0] exp_rdata;
        logic [1:0] exp_psel, one_r;
        mapped = ((addr / S) < NS) && ((addr % S) < WIN);
        k = mapped ? int'(addr / S) : 0;
        exp_psel = '0;
        if (mapped) exp_psel[k] = 1'b1;
        one_r = '0;
        one_r[r] = 1'b1;
        slv_wait = w;
        if (!mapped) begin
            exp_lat = 1; exp_err = 1'b1; exp_rdata = '0; exp_pen = 0;
        end else if (w > TO) begin
            exp_lat = 3 + TO; exp_err = 1'b1; exp_rdata = '0; exp_pen = TO + 1;
        end else begin
            exp_lat = 3 + w; exp_err = slv_err[k]; exp_rdata = wr ? 32'h0 : slv_rdata[k]; exp_pen = w + 1;
        end
        drive_req(r, wr, addr, wdata, strb, prot);
        req_valid = one_r;
        #1;
        n_checks++;
        if (req_ready !== one_r) begin
            n_fail++; $display("FAIL %s req_ready got %b want %b", tag, req_ready, one_r);
        end
        last_g = r;
        tick;
        req_valid = '0;
        drive_req(r, ~wr, $urandom, $urandom, 4'($urandom), 3'($urandom));
        c = 1;
        pen_cnt = 0;
        while (1) begin
            if (penable) pen_cnt++;
            if (c == 1 && mapped) begin
                n_checks++;
                if ({fsm_state, psel, penable, paddr, pwrite, pwdata, pstrb, pprot} !==
                    {3'd2, exp_psel, 1'b0, addr, wr, wdata, strb, prot}) begin
                    n_fail++;
                    $display("FAIL %s setup got st=%0d psel=%b en=%b a=%h w=%b d=%h s=%h p=%0d want st=2 psel=%b en=0 a=%h w=%b d=%h s=%h p=%0d",
                             tag, fsm_state, psel, penable, paddr, pwrite, pwdata, pstrb, pprot, exp_psel, addr, wr, wdata, strb, prot);
                end
            end
            if (c == 2 && mapped) begin
                n_checks++;
                if ({fsm_state, psel, penable, paddr} !== {3'd3, exp_psel, 1'b1, addr}) begin
                    n_fail++;
                    $display("FAIL %s access got st=%0d psel=%b en=%b a=%h want st=3 psel=%b en=1 a=%h",
                             tag, fsm_state, psel, penable, paddr, exp_psel, addr);
                end
            end
            if (c == 1 && !mapped) begin
                n_checks++;
                if ({fsm_state, psel, penable} !== {3'd1, 2'b00, 1'b0}) begin
                    n_fail++;
                    $display("FAIL %s unmapped bus got st=%0d psel=%b en=%b want st=1 psel=00 en=0", tag, fsm_state, psel, penable);
                end
            end
            if (rsp_valid !== 2'b00 || c >= 40) break;
            tick;
            c++;
        end
        n_checks++;
        if (c !== exp_lat) begin
            n_fail++; $display("FAIL %s latency got %0d want %0d", tag, c, exp_lat);
        end
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {one_r, exp_err, exp_rdata}) begin
            n_fail++;
            $display("FAIL %s response got v=%b e=%b d=%h want v=%b e=%b d=%h", tag, rsp_valid, rsp_err, rsp_rdata, one_r, exp_err, exp_rdata);
        end
        n_checks++;
        if (pen_cnt !== exp_pen) begin
            n_fail++; $display("FAIL %s penable_cycles got %0d want %0d", tag, pen_cnt, exp_pen);
        end
    endtask

    task automatic test_reset;
        preset = 1'b1;
        req_valid = 2'b01; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
        slv_err = '0; slv_rdata[0] = '0; slv_rdata[1] = '0;
        tick; tick;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata, pstrb, pprot, fsm_state} !==
            {2'b00, 2'b00, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 3'd1}) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b v=%b d=%h e=%b psel=%b en=%b st=%0d want all zero st=1",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, fsm_state);
        end
        req_valid = '0;
        preset = 1'b0;
        last_g = NR - 1;
        tick;
        n_checks++;
        if ({fsm_state, psel, penable, rsp_valid} !== {3'd1, 2'b00, 1'b0, 2'b00}) begin
            n_fail++; $display("FAIL reset_release got st=%0d psel=%b en=%b v=%b want 1 00 0 00", fsm_state, psel, penable, rsp_valid);
        end
    endtask

    task automatic test_single_write;
        slv_err = '0;
        slv_rdata[0] = $urandom;
        run_single(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, "single_write");
    endtask

    task automatic test_wait_read;
        slv_err = '0;
        slv_rdata[0] = 32'h12345678;
        run_single(1, 1'b0, 32'h100, $urandom, 4'hF, 3'd2, 3, "wait_read");
    endtask

    task automatic test_decode;
        slv_err = '0;
        slv_rdata[0] = $urandom; slv_rdata[1] = $urandom;
        run_single(0, 1'b0, 32'(WIN + 5), 32'h0, 4'h3, 3'd1, 0, "decode_slave1_base");
        run_single(1, 1'b0, 32'(WIN), 32'h0, 4'hF, 3'd0, 0, "decode_gap_first");
        run_single(0, 1'b1, 32'(S - 1), 32'h5, 4'hF, 3'd0, 0, "decode_gap_last");
        run_single(1, 1'b0, 32'(WIN - 1), 32'h0, 4'hF, 3'd4, 1, "decode_slave0_last");
        run_single(0, 1'b0, 32'(S + WIN - 1), 32'h0, 4'hF, 3'd7, 2, "decode_slave1_last");
        run_single(1, 1'b1, 32'(2 * S), 32'h9, 4'hF, 3'd0, 0, "decode_past_end");
    endtask

    task automatic test_timeout;
        slv_err = '0;
        slv_rdata[0] = 32'hCAFEF00D;
        run_single(0, 1'b0, 32'h20, 32'h0, 4'hF, 3'd0, 1000, "timeout");
        run_single(1, 1'b0, 32'h24, 32'h0, 4'hF, 3'd0, TO, "ready_on_last_cycle");
        run_single(0, 1'b0, 32'h28, 32'h0, 4'hF, 3'd0, TO - 1, "ready_before_limit");
        slv_err = 2'b01;
        run_single(1, 1'b1, 32'h2C, 32'h77, 4'hF, 3'd0, 0, "pslverr");
        slv_err = '0;
    endtask

    task automatic test_round_robin;
        int grants, prev, exp;
        logic [1:0] exp_oh;
        slv_wait = 0;
        slv_err = '0;
        grants = 0;
        prev = 0;
        drive_req(0, 1'b1, 32'h40, $urandom, 4'hF, 3'd0);
        drive_req(1, 1'b1, 32'(S + 8), $urandom, 4'hF, 3'd0);
        req_valid = 2'b11;
        #1;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            if (req_ready !== 2'b00) begin
                exp = rr_pick(last_g, req_valid);
                exp_oh = '0;
                exp_oh[exp] = 1'b1;
                n_checks++;
                if (req_ready !== exp_oh) begin
                    n_fail++; $display("FAIL rr_grant%0d got %b want %b", grants, req_ready, exp_oh);
                end
                if (grants > 0) begin
                    n_checks++;
                    if ((c - prev) !== 3 || rsp_valid === 2'b00) begin
                        n_fail++; $display("FAIL rr_spacing%0d got gap=%0d rsp=%b want gap=3 with rsp", grants, c - prev, rsp_valid);
                    end
                end
                last_g = exp;
                prev = c;
                grants++;
            end
            tick;
        end
        req_valid = '0;
        n_checks++;
        if (grants !== 4) begin
            n_fail++; $display("FAIL rr_grant_count got %0d want 4", grants);
        end
        for (int c = 0; c < 10 && rsp_valid === 2'b00; c++) tick;
        tick;
    endtask

    task automatic test_random;
        int r, typ, w;
        logic [31:0] addr;
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 1);
            typ = $urandom_range(0, 3);
            case (typ)
                0:       addr = 32'($urandom_range(0, WIN - 1));
                1:       addr = 32'(S) + 32'($urandom_range(0, WIN - 1));
                2:       addr = 32'(WIN) + 32'($urandom_range(0, 4));
                default: addr = 32'(2 * S) + 32'($urandom_range(0, 100000));
            endcase
            w = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
            slv_rdata[0] = $urandom; slv_rdata[1] = $urandom;
            slv_err = 2'($urandom_range(0, 3));
            run_single(r, 1'($urandom), addr, $urandom, 4'($urandom), 3'($urandom), w, "random");
        end
        slv_err = '0;
    endtask

    task automatic test_reset_mid;
        int exp;
        logic [1:0] exp_oh;
        slv_wait = 1000;
        drive_req(0, 1'b1, 32'h80, 32'h1, 4'hF, 3'd0);
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL rmid_grant got %b want 01", req_ready);
        end
        last_g = 0;
        tick;
        req_valid = '0;
        tick; tick;
        n_checks++;
        if ({fsm_state, penable} !== {3'd3, 1'b1}) begin
            n_fail++; $display("FAIL rmid_in_access got st=%0d en=%b want 3 1", fsm_state, penable);
        end
        preset = 1'b1;
        tick;
        preset = 1'b0;
        last_g = NR - 1;
        n_checks++;
        if ({fsm_state, psel, penable, rsp_valid} !== {3'd1, 2'b00, 1'b0, 2'b00}) begin
            n_fail++; $display("FAIL rmid_after_reset got st=%0d psel=%b en=%b v=%b want 1 00 0 00", fsm_state, psel, penable, rsp_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++;
            if ({rsp_valid, psel} !== 4'b0000) begin
                n_fail++; $display("FAIL rmid_no_response got v=%b psel=%b want 00 00", rsp_valid, psel);
            end
        end
        slv_wait = 0;
        drive_req(0, 1'b0, 32'h90, 32'h0, 4'hF, 3'd0);
        drive_req(1, 1'b0, 32'h94, 32'h0, 4'hF, 3'd0);
        req_valid = 2'b11;
        #1;
        exp = rr_pick(last_g, req_valid);
        exp_oh = '0;
        exp_oh[exp] = 1'b1;
        n_checks++;
        if (req_ready !== exp_oh) begin
            n_fail++; $display("FAIL rmid_priority got %b want %b", req_ready, exp_oh);
        end
        last_g = exp;
        tick;
        req_valid = '0;
        for (int c = 0; c < 10 && rsp_valid === 2'b00; c++) tick;
        n_checks++;
        if (rsp_valid !== exp_oh) begin
            n_fail++; $display("FAIL rmid_followup_rsp got %b want %b", rsp_valid, exp_oh);
        end
        tick;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_wait_read();
        test_decode();
        test_timeout();
        test_round_robin();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
